// File: rtl/i2f_norm.sv
`default_nettype none
// ============================================================================
// Module      : i2f_norm
// Description : Iterative signed integer to float normaliser. The magnitude is
//               shifted one bit per cycle until its top mantissa bit is set,
//               tracking a two's-complement exponent. There is no hidden bit.
// Revision    : 1.0 - initial release
// ============================================================================
module i2f_norm #(
    parameter int MAN = 23,
    parameter int EXP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAN+EXP:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [MAN+EXP:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int N = MAN + EXP + 1;

    localparam logic [N-1:0]   c_mag_one = {{(N-1){1'b0}}, 1'b1};
    localparam logic [EXP-1:0] c_exp_one = {{(EXP-1){1'b0}}, 1'b1};

    // The exponent must hold every reachable value, -(MAN-1) .. EXP+1.
    generate
        if (((EXP + 1) > ((1 << (EXP - 1)) - 1)) || ((MAN - 1) > (1 << (EXP - 1)))) begin : g_param_check
            $error("i2f_norm: EXP too narrow for the exponent range implied by MAN/EXP");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_sign;
    logic           w_sign_nxt;
    logic [N-1:0]   r_mag;
    logic [N-1:0]   w_mag_nxt;
    logic [EXP-1:0] r_exp;
    logic [EXP-1:0] w_exp_nxt;

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_exp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sign  <= w_sign_nxt;
            r_mag   <= w_mag_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    // Next-state and datapath update: capture, one normalising shift per cycle, hand-off.
    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_mag_nxt   = r_mag;
        w_exp_nxt   = r_exp;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sign_nxt  = in_data[N-1];
                    // Two's-complement negate; the most negative input wraps to 2^(N-1) unsigned.
                    w_mag_nxt   = in_data[N-1] ? (~in_data + c_mag_one) : in_data;
                    w_exp_nxt   = '0;
                    w_state_nxt = NORM;
                end
            end
            NORM: begin
                if (r_mag == '0) begin
                    w_state_nxt = DONE;
                end else if (r_mag[N-1:MAN] != '0) begin
                    // Dropped LSB is simply lost: truncation toward zero.
                    w_mag_nxt = r_mag >> 1;
                    w_exp_nxt = r_exp + c_exp_one;
                end else if (!r_mag[MAN-1]) begin
                    w_mag_nxt = r_mag << 1;
                    w_exp_nxt = r_exp - c_exp_one;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state; result is zero outside DONE.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        out_data  = '0;
        if (r_state == DONE) begin
            out_data = {r_sign, r_exp, r_mag[MAN-1:0]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2f_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2f_norm
// Description : Directed self-checking bench for i2f_norm (MAN=23, EXP=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2f_norm;

    localparam int MAN = 23;
    localparam int EXP = 8;
    localparam int N   = MAN + EXP + 1;

    logic         clk;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int n_checks;
    int n_fail;

    i2f_norm #(.MAN(MAN), .EXP(EXP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept din; cycle 0 is the clock period ending in the accepting edge.
    // While converting, in_valid stays high with junk data to prove it is ignored.
    // hold = number of cycles out_ready stays low once DONE is reached.
    task automatic convert(input string tag, input logic [N-1:0] din, input int k,
                           input logic [N-1:0] expected, input int hold);
        int   edges;
        bit   seen;
        logic [N-1:0] held;
        edges = 0;
        seen  = 1'b0;
        @(negedge clk);
        out_ready = (hold == 0);
        check_eq({tag, ".in_ready_idle"}, in_ready, 1);
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 32'hDEAD_BEEF;
        check_eq({tag, ".in_ready_busy"}, in_ready, 0);
        while (!seen && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid) seen = 1'b1;
        end
        in_valid = 1'b0;
        check_eq({tag, ".valid_seen"}, seen, 1);
        check_eq({tag, ".latency"}, edges + 1, k + 2);
        check_eq({tag, ".data"}, out_data, expected);
        if (hold > 0) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check_eq({tag, ".hold_data"}, out_data, held);
                check_eq({tag, ".hold_valid"}, out_valid, 1);
                check_eq({tag, ".hold_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq({tag, ".in_ready_after"}, in_ready, 1);
        check_eq({tag, ".valid_after"}, out_valid, 0);
    endtask

    initial begin
        int  edges;
        bit  seen;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset.in_ready", in_ready, 1);
        check_eq("reset.out_valid", out_valid, 0);
        check_eq("reset.out_data", out_data, 0);

        convert("one",      32'h0000_0001, 22, 32'h7540_0000, 0);
        convert("minus3",   32'hFFFF_FFFD, 21, 32'hF5E0_0000, 0);
        convert("maxpos",   32'h7FFF_FFFF,  8, 32'h047F_FFFF, 0);
        convert("minneg",   32'h8000_0000,  9, 32'h84C0_0000, 0);
        convert("zero",     32'h0000_0000,  0, 32'h0000_0000, 0);
        convert("normed",   32'h0040_0000,  0, 32'h0040_0000, 0);
        convert("bit23",    32'h0080_0000,  1, 32'h00C0_0000, 0);
        convert("minus1",   32'hFFFF_FFFF, 22, 32'hF540_0000, 0);
        convert("trunc2",   32'h01FF_FFFF,  2, 32'h017F_FFFF, 0);
        convert("hold",     32'hFFFF_FFFD, 21, 32'hF5E0_0000, 5);

        // Reset in cycle 5 of converting 1: no result may ever appear.
        @(negedge clk);
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_norm.in_ready", in_ready, 1);
        check_eq("rst_norm.out_valid", out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("rst_norm.no_pulse", seen, 0);
        convert("after_rst", 32'h7FFF_FFFF, 8, 32'h047F_FFFF, 0);

        // Reset while stalled in DONE, with in_valid and out_ready high in the same edge.
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = 32'h0000_0000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq("rst_done.reached", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("rst_done.out_valid", out_valid, 0);
        check_eq("rst_done.in_ready", in_ready, 1);
        check_eq("rst_done.out_data", out_data, 0);
        @(posedge clk);
        #1;
        check_eq("rst_done.no_accept", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
